// File: rtl/xup_nand_vector_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : xup_nand_vector_arbiter
// Brief    : Round-robin sequencer sharing one NAND vector unit among requesters;
//            optional op counter enabled by XUP_NAND_ARB_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module xup_nand_vector_arbiter #(
    parameter int SIZE       = 4,
    parameter int NUM_REQ    = 4,
    parameter int SETTLE_CYC = 1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [NUM_REQ-1:0]      req,
    input  logic [NUM_REQ*SIZE-1:0] a_in,
    input  logic [NUM_REQ*SIZE-1:0] b_in,
    output logic [NUM_REQ-1:0]      gnt,
    output logic [NUM_REQ-1:0]      done,
    output logic [SIZE-1:0]         y_out,
    output logic                    busy,
    output logic [SIZE-1:0]         nand_a,
    output logic [SIZE-1:0]         nand_b,
`ifdef XUP_NAND_ARB_STATS_EN
    output logic [15:0]             op_count,
`endif
    input  logic [SIZE-1:0]         nand_y
);
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_SETTLE  = 2'd1;
    localparam logic [1:0] S_CAPTURE = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [SIZE-1:0]    y_q, y_d;
    logic [SIZE-1:0]    na_q, na_d;
    logic [SIZE-1:0]    nb_q, nb_d;
    logic               busy_q, busy_d;

    logic [SIZE-1:0]    a_arr [NUM_REQ];
    logic [SIZE-1:0]    b_arr [NUM_REQ];
    logic               win_valid;
    logic [PW-1:0]      win_idx;
    logic [PW:0]        cand;

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign a_arr[k] = a_in[k*SIZE +: SIZE];
        assign b_arr[k] = b_in[k*SIZE +: SIZE];
    end

    // Scan from the highest offset down so the request nearest rr_ptr wins last.
    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, rr_ptr_q} + (PW+1)'(i);
            if (cand >= (PW+1)'(NUM_REQ)) begin
                cand = cand - (PW+1)'(NUM_REQ);
            end
            if (req[cand[PW-1:0]]) begin
                win_valid = 1'b1;
                win_idx   = cand[PW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            owner_q  <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            y_q      <= '0;
            na_q     <= '0;
            nb_q     <= '0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            owner_q  <= owner_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            y_q      <= y_d;
            na_q     <= na_d;
            nb_q     <= nb_d;
            busy_q   <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    state_d = S_SETTLE;
                    cnt_d   = CW'(SETTLE_CYC - 1);
                end
            end
            S_SETTLE: begin
                if (cnt_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_CAPTURE: state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // busy stays up through the done cycle because CAPTURE sets it for the next one.
    always_comb begin
        gnt_d    = '0;
        done_d   = '0;
        busy_d   = 1'b0;
        rr_ptr_d = rr_ptr_q;
        owner_d  = owner_q;
        y_d      = y_q;
        na_d     = na_q;
        nb_d     = nb_q;
        case (state_q)
            S_IDLE: begin
                if (win_valid) begin
                    gnt_d[win_idx] = 1'b1;
                    busy_d         = 1'b1;
                    owner_d        = win_idx;
                    na_d           = a_arr[win_idx];
                    nb_d           = b_arr[win_idx];
                    rr_ptr_d       = (win_idx == PW'(NUM_REQ - 1)) ? '0 : win_idx + PW'(1);
                end
            end
            S_SETTLE: busy_d = 1'b1;
            S_CAPTURE: begin
                busy_d          = 1'b1;
                y_d             = nand_y;
                done_d[owner_q] = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef XUP_NAND_ARB_STATS_EN
    logic [15:0] op_count_q, op_count_d;

    always_comb begin
        op_count_d = op_count_q;
        if (state_q == S_CAPTURE) begin
            op_count_d = op_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_count_q <= '0;
        end else begin
            op_count_q <= op_count_d;
        end
    end

    assign op_count = op_count_q;
`endif

    assign gnt    = gnt_q;
    assign done   = done_q;
    assign y_out  = y_q;
    assign busy   = busy_q;
    assign nand_a = na_q;
    assign nand_b = nb_q;

endmodule
`default_nettype wire

// File: tb/tb_xup_nand_vector_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_xup_nand_vector_arbiter
// Brief    : Two arbiters (settle 1 and 3) driven by shared requester intents and
//            checked each cycle against a transaction-timeline reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_xup_nand_vector_arbiter;
    localparam int NU = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [3:0]  req    [NU];
    logic [15:0] a_in   [NU];
    logic [15:0] b_in   [NU];
    logic [3:0]  gnt    [NU];
    logic [3:0]  done   [NU];
    logic [3:0]  y_out  [NU];
    logic        busy   [NU];
    logic [3:0]  nand_a [NU];
    logic [3:0]  nand_b [NU];
    logic [3:0]  nand_y [NU];
`ifdef XUP_NAND_ARB_STATS_EN
    logic [15:0] op_count [NU];
`endif

    logic [3:0]  want [NU];
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    for (genvar u = 0; u < NU; u++) begin : g_dut
        xup_nand_vector_arbiter #(
            .SIZE      (4),
            .NUM_REQ   (4),
            .SETTLE_CYC((u == 0) ? 1 : 3)
        ) dut (
            .clk     (clk),
            .reset_n (reset_n),
            .req     (req[u]),
            .a_in    (a_in[u]),
            .b_in    (b_in[u]),
            .gnt     (gnt[u]),
            .done    (done[u]),
            .y_out   (y_out[u]),
            .busy    (busy[u]),
            .nand_a  (nand_a[u]),
            .nand_b  (nand_b[u]),
`ifdef XUP_NAND_ARB_STATS_EN
            .op_count(op_count[u]),
`endif
            .nand_y  (nand_y[u])
        );
        assign nand_y[u] = ~(nand_a[u] & nand_b[u]);
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic int settle_of(input int u);
        return (u == 0) ? 1 : 3;
    endfunction

    // Reference: each accepted op occupies a timeline of ages 0 (grant) .. S+1 (done).
    bit          m_active [NU] = '{default: 1'b0};
    int          m_age    [NU] = '{default: 0};
    int          m_rr     [NU] = '{default: 0};
    int          m_owner  [NU] = '{default: 0};
    logic [3:0]  m_y      [NU] = '{default: 4'h0};
    logic [3:0]  m_na     [NU] = '{default: 4'h0};
    logic [3:0]  m_nb     [NU] = '{default: 4'h0};
    logic [15:0] m_cnt    [NU] = '{default: 16'h0};
    int          win;
    bit          found;
    int          kk;

    always @(posedge clk or negedge reset_n) begin
        for (int u = 0; u < NU; u++) begin
            if (!reset_n) begin
                m_active[u] = 1'b0; m_age[u] = 0; m_rr[u] = 0; m_owner[u] = 0;
                m_y[u] = 4'h0; m_na[u] = 4'h0; m_nb[u] = 4'h0; m_cnt[u] = 16'h0;
            end else begin
                if (m_active[u]) begin
                    if (m_age[u] == settle_of(u) + 1) begin
                        m_active[u] = 1'b0;
                    end else begin
                        m_age[u]++;
                        if (m_age[u] == settle_of(u) + 1) begin
                            m_y[u]   = ~(m_na[u] & m_nb[u]);
                            m_cnt[u] = m_cnt[u] + 16'd1;
                        end
                    end
                end
                if (!m_active[u] && req[u] != 4'h0) begin
                    found = 1'b0;
                    win   = 0;
                    for (int i = 0; i < 4; i++) begin
                        kk = (m_rr[u] + i) % 4;
                        if (!found && req[u][kk]) begin
                            found = 1'b1;
                            win   = kk;
                        end
                    end
                    m_active[u] = 1'b1;
                    m_age[u]    = 0;
                    m_owner[u]  = win;
                    m_na[u]     = a_in[u][win*4 +: 4];
                    m_nb[u]     = b_in[u][win*4 +: 4];
                    m_rr[u]     = (win + 1) % 4;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int u = 0; u < NU; u++) begin
            logic [3:0] eg;
            logic [3:0] ed;
            eg = (m_active[u] && m_age[u] == 0) ? 4'(1 << m_owner[u]) : 4'h0;
            ed = (m_active[u] && m_age[u] == settle_of(u) + 1) ? 4'(1 << m_owner[u]) : 4'h0;
            check_eq($sformatf("u%0d gnt", u),    32'(gnt[u]),    32'(eg));
            check_eq($sformatf("u%0d done", u),   32'(done[u]),   32'(ed));
            check_eq($sformatf("u%0d busy", u),   32'(busy[u]),   32'(m_active[u]));
            check_eq($sformatf("u%0d y_out", u),  32'(y_out[u]),  32'(m_y[u]));
            check_eq($sformatf("u%0d nand_a", u), 32'(nand_a[u]), 32'(m_na[u]));
            check_eq($sformatf("u%0d nand_b", u), 32'(nand_b[u]), 32'(m_nb[u]));
`ifdef XUP_NAND_ARB_STATS_EN
            check_eq($sformatf("u%0d op_count", u), 32'(op_count[u]), 32'(m_cnt[u]));
`endif
        end
    end

    // Requesters hold req until they see their grant, then drop it.
    task automatic tick(input int n = 1);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            #1;
            for (int u = 0; u < NU; u++) begin
                want[u] = want[u] & ~gnt[u];
                req[u]  = want[u];
            end
        end
    endtask

    task automatic raise(input logic [3:0] bits);
        for (int u = 0; u < NU; u++) want[u] = want[u] | bits;
    endtask

    task automatic lower(input logic [3:0] bits);
        for (int u = 0; u < NU; u++) want[u] = want[u] & ~bits;
    endtask

    task automatic set_ops(input int k, input logic [3:0] a, input logic [3:0] b);
        for (int u = 0; u < NU; u++) begin
            a_in[u][k*4 +: 4] = a;
            b_in[u][k*4 +: 4] = b;
        end
    endtask

    initial begin
        for (int u = 0; u < NU; u++) begin
            want[u] = 4'h0; req[u] = 4'h0; a_in[u] = 16'h0; b_in[u] = 16'h0;
        end
        tick(3);
        reset_n = 1'b1;
        tick(2);

        set_ops(0, 4'b1100, 4'b1010);
        raise(4'b0001);
        tick(10);

        set_ops(0, 4'h3, 4'h5); set_ops(1, 4'h9, 4'hE);
        set_ops(2, 4'h6, 4'h7); set_ops(3, 4'hC, 4'hB);
        for (int c = 0; c < 24; c++) begin
            raise(4'b1111);
            tick();
        end
        lower(4'b1111);
        tick(10);

        raise(4'b1000);
        tick(10);
        raise(4'b1001);
        tick(14);

        raise(4'b0001);
        tick(2);
        raise(4'b0010);
        tick();
        lower(4'b0010);
        tick(10);

        set_ops(0, 4'hF, 4'hF);
        raise(4'b0001);
        tick(10);

        raise(4'b0100);
        tick(2);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        for (int u = 0; u < NU; u++) begin
            want[u] = 4'h0; req[u] = 4'h0;
        end
        tick(3);
        reset_n = 1'b1;
        tick(8);

        for (int c = 0; c < 400; c++) begin
            for (int u = 0; u < NU; u++) begin
                a_in[u] = 16'($urandom);
                b_in[u] = 16'($urandom);
            end
            if ($urandom_range(0, 2) == 0) raise(4'($urandom_range(0, 15)));
            if ($urandom_range(0, 7) == 0) lower(4'(1 << $urandom_range(0, 3)));
            tick();
        end
        lower(4'b1111);
        tick(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
